// File: rtl/fft8_bitrev_reorder.sv
// fft8_bitrev_reorder: ping-pong buffer that turns bit-reversed 8-point FFT output
// into natural bin order, tagged with bin index and frame start/end.
module fft8_bitrev_reorder #(
    parameter int DATA_W = 37,
    parameter int N_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic [2:0]        out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_err
);
    localparam int N = 1 << N_LOG2;
    typedef enum logic {IDLE, READ} state_t;
    state_t            state;
    logic [DATA_W-1:0] mem [2][N];
    logic [2:0]        wcnt, rcnt, wpos, wr_idx, rd_cnt;
    logic              wbank, rbank, rd_bank;
    logic [1:0]        full, set_mask, clr_mask;
    logic              acc, frame_done, rd_active, rd_last, cont;
    // a sop always restarts the frame at arrival 0, discarding any partial frame
    assign wpos       = in_sop ? 3'd0 : wcnt;
    assign wr_idx     = {wpos[0], wpos[1], wpos[2]};
    assign acc        = in_valid & (in_sop | (wcnt != 3'd0));
    assign frame_done = acc & (wpos == 3'd7);
    assign set_mask   = {frame_done & wbank, frame_done & ~wbank};
    // leaving IDLE emits bin 0 on the same edge so bin 0 lands one cycle after the frame
    assign rd_active  = (state == READ) | (|full);
    assign rd_bank    = (state == IDLE) ? ~full[0] : rbank;
    assign rd_cnt     = (state == IDLE) ? 3'd0 : rcnt;
    assign rd_last    = rd_active & (rd_cnt == 3'd7);
    assign clr_mask   = {rd_last & rd_bank, rd_last & ~rd_bank};
    assign cont       = full[~rd_bank] | set_mask[~rd_bank];
    always_ff @(posedge clk) begin
        if (acc) mem[wbank][wr_idx] <= in_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= 3'd0;
            rcnt      <= 3'd0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            full      <= 2'b00;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_idx   <= 3'd0;
            out_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= in_valid & (in_sop == (wcnt != 3'd0));
            if (acc) wcnt <= wpos + 3'd1;
            if (frame_done) wbank <= ~wbank;
            full      <= (full | set_mask) & ~clr_mask;
            out_valid <= rd_active;
            out_sop   <= rd_active & (rd_cnt == 3'd0);
            out_eop   <= rd_last;
            if (rd_active) begin
                out_data <= mem[rd_bank][rd_cnt];
                out_idx  <= rd_cnt;
            end
            if (rd_last) begin
                state <= cont ? READ : IDLE;
                rbank <= ~rd_bank;
                rcnt  <= 3'd0;
            end else if (rd_active) begin
                state <= READ;
                rbank <= rd_bank;
                rcnt  <= rd_cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_fft8_bitrev_reorder.sv
// tb_fft8_bitrev_reorder: directed and random frames checked cycle by cycle against
// a frame-level model that schedules natural-order readouts.
module tb_fft8_bitrev_reorder;
    localparam int DW = 37;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_sop = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid, out_sop, out_eop, frame_err;
    logic [2:0]    out_idx;
    logic [DW-1:0] out_data;

    fft8_bitrev_reorder #(.DATA_W(DW), .N_LOG2(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_idx(out_idx),
        .out_data(out_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {int c; logic [DW-1:0] d; logic [2:0] i;} exp_t;
    exp_t          q[$];
    logic [DW-1:0] seen[$];
    logic [DW-1:0] fbuf[8];
    int            cyc = 0, cnt = 0, next_free = 0, errs = 0;
    int            checks = 0, errors = 0;
    logic          err_exp = 1'b0;
    int            ord[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic int bitrev(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    // model: collect arrivals, on frame completion schedule 8 natural-order outputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cnt = 0;
            next_free = 0;
            err_exp = 1'b0;
        end else begin
            cyc++;
            err_exp = 1'b0;
            if (in_valid) begin
                if (in_sop && cnt != 0) err_exp = 1'b1;
                if (in_sop) cnt = 0;
                if (!in_sop && cnt == 0) err_exp = 1'b1;
                else begin
                    fbuf[cnt] = in_data;
                    cnt++;
                    if (cnt == 8) begin
                        int start;
                        start = (cyc + 1 > next_free) ? cyc + 1 : next_free;
                        for (int k = 0; k < 8; k++) q.push_back('{start + k, fbuf[bitrev(k)], 3'(k)});
                        next_free = start + 8;
                        cnt = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [43:0] act, expv;
            logic        ev;
            ev   = (q.size() > 0) && (q[0].c == cyc);
            expv = ev ? {1'b1, q[0].i == 3'd0, q[0].i == 3'd7, q[0].i, q[0].d, err_exp}
                      : {6'b0, {DW{1'b0}}, err_exp};
            act  = {out_valid, out_sop, out_eop, out_valid ? out_idx : 3'd0,
                    out_valid ? out_data : {DW{1'b0}}, frame_err};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle %0d outputs act=%h exp=%h", cyc, act, expv);
            end
            if (ev) void'(q.pop_front());
            if (out_valid) seen.push_back(out_data);
            if (frame_err) errs++;
        end
    end

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_sop   = s;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic frame(input int base, input bit gap);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, DW'(base + i));
            if (gap) drive(1'b0, 1'b0, '0);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic pin(input string nm, input int base, input int off);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seen.size() <= off + k) begin
                errors++;
                $display("FAIL %s bin%0d missing", nm, k);
            end else if (seen[off + k] !== DW'(base + ord[k])) begin
                errors++;
                $display("FAIL %s bin%0d act=%0d exp=%0d", nm, k, seen[off + k], base + ord[k]);
            end
        end
    endtask

    task automatic restart;
        seen.delete();
        errs = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_int("reset_outputs", int'({out_valid, out_sop, out_eop, out_idx, frame_err}), 0);
        check_int("reset_data", int'(out_data), 0);
        rst_n = 1'b1;
        idle(2);
        // T1 single frame
        restart();
        frame(100, 0);
        idle(12);
        pin("t1", 100, 0);
        check_int("t1_count", seen.size(), 8);
        // T2 back-to-back
        restart();
        frame(100, 0);
        frame(200, 0);
        idle(12);
        pin("t2a", 100, 0);
        pin("t2b", 200, 8);
        check_int("t2_count", seen.size(), 16);
        // T3 gapped input
        restart();
        frame(100, 1);
        idle(12);
        pin("t3", 100, 0);
        check_int("t3_err", errs, 0);
        // T4 early sop
        restart();
        drive(1'b1, 1'b1, DW'(1));
        drive(1'b1, 1'b0, DW'(2));
        drive(1'b1, 1'b0, DW'(3));
        frame(300, 0);
        idle(12);
        pin("t4", 300, 0);
        check_int("t4_count", seen.size(), 8);
        check_int("t4_err", errs, 1);
        // T5 missing sop
        restart();
        drive(1'b1, 1'b0, DW'(55));
        frame(100, 0);
        idle(12);
        pin("t5", 100, 0);
        check_int("t5_count", seen.size(), 8);
        check_int("t5_err", errs, 1);
        // T6 reset mid-readout
        restart();
        frame(100, 0);
        begin
            bit hit = 0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_sop   = 1'b0;
                if (out_valid && out_idx == 3'd3) hit = 1;
            end
            check_int("t6_reach_bin3", int'(hit), 1);
        end
        #2 rst_n = 1'b0;
        #1 check_int("t6_async_clear", int'({out_valid, out_sop, out_eop, out_idx, frame_err}), 0);
        check_int("t6_data_clear", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        restart();
        frame(400, 0);
        idle(12);
        pin("t6", 400, 0);
        check_int("t6_count", seen.size(), 8);
        // random frames with gaps, truncations and stray words
        for (int f = 0; f < 60; f++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) drive(1'b1, 1'b0, DW'({$urandom(), $urandom()}));
            if (r == 1) for (int i = 0; i < $urandom_range(1, 7); i++)
                drive(1'b1, i == 0, DW'({$urandom(), $urandom()}));
            for (int i = 0; i < 8; i++) begin
                drive(1'b1, i == 0, DW'({$urandom(), $urandom()}));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(20);
        check_int("random_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
